// File: rtl/eth_mac_tx_cfg_if.sv
// AXI-Stream byte channel that feeds the MAC transmit engine.
interface eth_mac_tx_cfg_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tuser;
    logic       tready;

    modport master (
        output tdata, tvalid, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tvalid, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/eth_mac_tx_cfg.sv
// Ethernet MAC transmit engine: AXI-Stream bytes to GMII with preamble,
// padding, FCS, inter-frame gap, abort on underrun/truncation and counters.
module eth_mac_tx_cfg #(
    parameter int MIN_FRAME_LEN = 60,
    parameter int MAX_FRAME_LEN = 1514,
    parameter int IFG_BYTES     = 12,
    parameter int ENABLE_PAD    = 1,
    parameter int ENABLE_FCS    = 1,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    eth_mac_tx_cfg_if.slave      s_axis,
    output logic [7:0]           gmii_txd,
    output logic                 gmii_tx_en,
    output logic                 gmii_tx_er,
    output logic                 tx_busy,
    output logic [CNT_WIDTH-1:0] tx_frame_count,
    output logic [CNT_WIDTH-1:0] tx_error_count
);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, SFD, DATA, PAD, FCS, DRAIN, IFG
    } state_t;

    // The IDLE sampling cycle is itself one low cycle of the gap,
    // so the IFG state only covers the remaining IFG_BYTES-1 cycles.
    localparam state_t      END_ST   = (IFG_BYTES > 1) ? IFG : IDLE;
    localparam logic [15:0] IFG_LAST = 16'((IFG_BYTES > 1) ? IFG_BYTES - 2 : 0);
    localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME_LEN);
    localparam logic [15:0] MAX_LEN  = 16'(MAX_FRAME_LEN);

    state_t      state, state_nx;
    logic [15:0] byte_cnt, byte_cnt_nx, byte_inc, cnt;
    logic [31:0] crc, crc_nx, fcs;
    logic        bad, bad_nx, done;
    logic [7:0]  txd_nx;
    logic        en_nx, er_nx;

    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  d
    );
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    assign s_axis.tready = (state == DATA) || (state == DRAIN);
    assign byte_inc      = byte_cnt + 16'd1;
    assign fcs           = ~crc;

    always_comb begin
        state_nx    = state;
        byte_cnt_nx = byte_cnt;
        crc_nx      = crc;
        bad_nx      = bad;
        done        = 1'b0;
        txd_nx      = 8'h00;
        en_nx       = 1'b0;
        er_nx       = 1'b0;
        unique case (state)
            IDLE: begin
                byte_cnt_nx = '0;
                bad_nx      = 1'b0;
                if (s_axis.tvalid) state_nx = PREAMBLE;
            end
            PREAMBLE: begin
                txd_nx = 8'h55;
                en_nx  = 1'b1;
                if (cnt == 16'd6) state_nx = SFD;
            end
            SFD: begin
                txd_nx   = 8'hD5;
                en_nx    = 1'b1;
                crc_nx   = '1;
                state_nx = DATA;
            end
            DATA: begin
                en_nx = 1'b1;
                if (!s_axis.tvalid) begin
                    er_nx    = 1'b1;
                    bad_nx   = 1'b1;
                    state_nx = DRAIN;
                end else begin
                    txd_nx      = s_axis.tdata;
                    er_nx       = s_axis.tuser;
                    bad_nx      = bad | s_axis.tuser;
                    crc_nx      = crc_byte(crc, s_axis.tdata);
                    byte_cnt_nx = byte_inc;
                    if (byte_cnt == MAX_LEN) begin
                        er_nx  = 1'b1;
                        bad_nx = 1'b1;
                        if (s_axis.tlast) begin
                            state_nx = END_ST;
                            done     = 1'b1;
                        end else begin
                            state_nx = DRAIN;
                        end
                    end else if (s_axis.tlast) begin
                        if (ENABLE_PAD != 0 && byte_inc < MIN_LEN) begin
                            state_nx = PAD;
                        end else if (ENABLE_FCS != 0) begin
                            state_nx = FCS;
                        end else begin
                            state_nx = END_ST;
                            done     = 1'b1;
                        end
                    end
                end
            end
            PAD: begin
                en_nx       = 1'b1;
                crc_nx      = crc_byte(crc, 8'h00);
                byte_cnt_nx = byte_inc;
                if (byte_inc == MIN_LEN) begin
                    if (ENABLE_FCS != 0) begin
                        state_nx = FCS;
                    end else begin
                        state_nx = END_ST;
                        done     = 1'b1;
                    end
                end
            end
            FCS: begin
                txd_nx = fcs[{cnt[1:0], 3'b000} +: 8];
                en_nx  = 1'b1;
                if (cnt == 16'd3) begin
                    state_nx = END_ST;
                    done     = 1'b1;
                end
            end
            DRAIN: begin
                if (s_axis.tvalid && s_axis.tlast) begin
                    state_nx = END_ST;
                    done     = 1'b1;
                end
            end
            IFG: begin
                if (cnt == IFG_LAST) state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            byte_cnt       <= '0;
            crc            <= '1;
            bad            <= 1'b0;
            gmii_txd       <= 8'h00;
            gmii_tx_en     <= 1'b0;
            gmii_tx_er     <= 1'b0;
            tx_busy        <= 1'b0;
            tx_frame_count <= '0;
            tx_error_count <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= (state_nx != state) ? 16'd0 : cnt + 16'd1;
            byte_cnt   <= byte_cnt_nx;
            crc        <= crc_nx;
            bad        <= bad_nx;
            gmii_txd   <= txd_nx;
            gmii_tx_en <= en_nx;
            gmii_tx_er <= er_nx;
            tx_busy    <= (state != IDLE);
            if (done) begin
                if (bad_nx) tx_error_count <= tx_error_count + CNT_WIDTH'(1);
                else        tx_frame_count <= tx_frame_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_eth_mac_tx_cfg.sv
// Scoreboard bench for eth_mac_tx_cfg: a default instance plus an
// unpadded instance used for the CRC known-answer frame.
module tb_eth_mac_tx_cfg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic [7:0] tdata;
    logic       tvalid, tlast, tuser;

    eth_mac_tx_cfg_if ifa ();
    eth_mac_tx_cfg_if ifb ();

    assign ifa.tdata  = tdata;
    assign ifa.tvalid = tvalid & ~sel;
    assign ifa.tlast  = tlast;
    assign ifa.tuser  = tuser;
    assign ifb.tdata  = tdata;
    assign ifb.tvalid = tvalid & sel;
    assign ifb.tlast  = tlast;
    assign ifb.tuser  = tuser;

    logic [7:0]  txd0, txd1;
    logic        en0, en1, er0, er1, busy0, busy1;
    logic [15:0] fc0, fc1, ec0, ec1;

    eth_mac_tx_cfg u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axis         (ifa),
        .gmii_txd       (txd0),
        .gmii_tx_en     (en0),
        .gmii_tx_er     (er0),
        .tx_busy        (busy0),
        .tx_frame_count (fc0),
        .tx_error_count (ec0)
    );

    eth_mac_tx_cfg #(.ENABLE_PAD(0)) u_dut_np (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axis         (ifb),
        .gmii_txd       (txd1),
        .gmii_tx_en     (en1),
        .gmii_tx_er     (er1),
        .tx_busy        (busy1),
        .tx_frame_count (fc1),
        .tx_error_count (ec1)
    );

    logic [7:0]  m_txd;
    logic        m_en, m_er, m_busy, m_ready;
    logic [15:0] m_fc, m_ec;

    assign m_txd   = sel ? txd1 : txd0;
    assign m_en    = sel ? en1 : en0;
    assign m_er    = sel ? er1 : er0;
    assign m_busy  = sel ? busy1 : busy0;
    assign m_ready = sel ? ifb.tready : ifa.tready;
    assign m_fc    = sel ? fc1 : fc0;
    assign m_ec    = sel ? ec1 : ec0;

    int          tests = 0;
    int          fails = 0;
    int          exp_fc = 0;
    int          exp_ec = 0;
    logic [9:0]  obs[$];
    logic [8:0]  expq[$];
    logic [7:0]  payload[$];

    always #5 clk = ~clk;

    always @(negedge clk) obs.push_back({m_er, m_en, m_txd});

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++)
            r = (r[0] ^ d[b]) ? ({1'b0, r[31:1]} ^ 32'hEDB88320) : {1'b0, r[31:1]};
        return r;
    endfunction

    task automatic fill_payload(input int len);
        payload.delete();
        for (int i = 0; i < len; i++) payload.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic push_frame(input int len, input int gap_at, input int user_at,
                              input bit pad, input bit fcs, input int maxlen);
        logic [31:0] crc;
        logic [31:0] f;
        int          n;
        crc = 32'hFFFFFFFF;
        n   = 0;
        repeat (7) expq.push_back({1'b0, 8'h55});
        expq.push_back({1'b0, 8'hD5});
        for (int i = 0; i < len; i++) begin
            if (i == gap_at) begin
                expq.push_back({1'b1, 8'h00});
                return;
            end
            if (i == maxlen) begin
                expq.push_back({1'b1, payload[i]});
                return;
            end
            expq.push_back({i == user_at, payload[i]});
            crc = crc_upd(crc, payload[i]);
            n++;
        end
        if (pad) begin
            while (n < 60) begin
                expq.push_back({1'b0, 8'h00});
                crc = crc_upd(crc, 8'h00);
                n++;
            end
        end
        if (fcs) begin
            f = ~crc;
            for (int k = 0; k < 4; k++) expq.push_back({1'b0, f[8*k +: 8]});
        end
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic last, input logic user);
        tdata  = d;
        tvalid = 1'b1;
        tlast  = last;
        tuser  = user;
        for (int t = 0; t < 400; t++) begin
            if (m_ready) begin
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        tests++;
        fails++;
        $display("FAIL drive_timeout: tready=%b, required 1 within 400 cycles", m_ready);
    endtask

    task automatic send(input int len, input int gap_at, input int gap_len,
                        input int user_at, input bit hold);
        for (int i = 0; i < len; i++) begin
            if (i == gap_at) begin
                tvalid = 1'b0;
                repeat (gap_len) @(negedge clk);
            end
            drive_byte(payload[i], i == len - 1, i == user_at);
        end
        if (!hold) begin
            tvalid = 1'b0;
            tlast  = 1'b0;
            tuser  = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (m_busy && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (m_busy) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: tx_busy=%b, required 0", name, m_busy);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_wire(input string name, input int exp_segs,
                              input int exp_gap, input int exp_en);
        logic [9:0] e;
        logic [8:0] x;
        int         segs, low, en_n, shown;
        bit         prev, seen;
        segs = 0; low = 0; en_n = 0; shown = 0; prev = 0; seen = 0;
        while (obs.size() > 0) begin
            e = obs.pop_front();
            if (e[8]) begin
                if (!prev) begin
                    segs++;
                    if (seen && exp_gap >= 0) begin
                        tests++;
                        if (low != exp_gap) begin
                            fails++;
                            $display("FAIL %s_gap: got %0d low cycles, expected %0d", name, low, exp_gap);
                        end
                    end
                end
                seen = 1;
                low  = 0;
                en_n++;
                tests++;
                if (expq.size() == 0) begin
                    fails++;
                    if (shown++ < 4)
                        $display("FAIL %s_extra: byte %0d txd=%02h er=%b, expected no byte", name, en_n - 1, e[7:0], e[9]);
                end else begin
                    x = expq.pop_front();
                    if ({e[9], e[7:0]} !== x) begin
                        fails++;
                        if (shown++ < 4)
                            $display("FAIL %s_byte%0d: got er=%b txd=%02h, expected er=%b txd=%02h", name, en_n - 1, e[9], e[7:0], x[8], x[7:0]);
                    end
                end
            end else begin
                low++;
            end
            prev = e[8];
        end
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL %s_missing: %0d bytes not sent, expected 0", name, expq.size());
            expq.delete();
        end
        tests++;
        if (segs != exp_segs) begin
            fails++;
            $display("FAIL %s_segments: got %0d tx_en bursts, expected %0d", name, segs, exp_segs);
        end
        tests++;
        if (en_n != exp_en) begin
            fails++;
            $display("FAIL %s_en_cycles: got %0d, expected %0d", name, en_n, exp_en);
        end
    endtask

    task automatic check_counts(input string name, input int efc, input int eec);
        tests++;
        if (m_fc !== 16'(efc)) begin
            fails++;
            $display("FAIL %s_frame_count: got %0d, expected %0d", name, m_fc, efc);
        end
        tests++;
        if (m_ec !== 16'(eec)) begin
            fails++;
            $display("FAIL %s_error_count: got %0d, expected %0d", name, m_ec, eec);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        tests++;
        if ({m_txd, m_en, m_er, m_busy, m_ready} !== 12'h000) begin
            fails++;
            $display("FAIL %s_outputs: txd=%02h en=%b er=%b busy=%b ready=%b, expected all 0",
                     name, m_txd, m_en, m_er, m_busy, m_ready);
        end
        check_counts(name, 0, 0);
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check_idle_outputs("reset");
        end
        sel = 1'b0;
    endtask

    task automatic test_crc_vector();
        sel = 1'b1;
        payload.delete();
        for (int i = 0; i < 9; i++) payload.push_back(8'h31 + 8'(i));
        obs.delete();
        push_frame(9, -1, -1, 1'b0, 1'b0, 9999);
        expq.push_back({1'b0, 8'h26});
        expq.push_back({1'b0, 8'h39});
        expq.push_back({1'b0, 8'hF4});
        expq.push_back({1'b0, 8'hCB});
        send(9, -1, 0, -1, 1'b0);
        wait_idle("crc_vector");
        check_wire("crc_vector", 1, -1, 21);
        check_counts("crc_vector", 1, 0);
        sel = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_pad();
        fill_payload(10);
        obs.delete();
        push_frame(10, -1, -1, 1'b1, 1'b1, 1514);
        send(10, -1, 0, -1, 1'b0);
        wait_idle("pad");
        check_wire("pad", 1, -1, 72);
        exp_fc++;
        check_counts("pad", exp_fc, exp_ec);
    endtask

    task automatic test_underrun();
        fill_payload(40);
        obs.delete();
        push_frame(40, 20, -1, 1'b1, 1'b1, 1514);
        send(40, 20, 3, -1, 1'b0);
        wait_idle("underrun");
        check_wire("underrun", 1, -1, 29);
        exp_ec++;
        check_counts("underrun", exp_fc, exp_ec);
    endtask

    task automatic test_truncation();
        fill_payload(1520);
        obs.delete();
        push_frame(1520, -1, -1, 1'b1, 1'b1, 1514);
        send(1520, -1, 0, -1, 1'b0);
        wait_idle("truncation");
        check_wire("truncation", 1, -1, 1523);
        exp_ec++;
        check_counts("truncation", exp_fc, exp_ec);
    endtask

    task automatic test_back_to_back();
        fill_payload(64);
        obs.delete();
        push_frame(64, -1, -1, 1'b1, 1'b1, 1514);
        push_frame(64, -1, -1, 1'b1, 1'b1, 1514);
        send(64, -1, 0, -1, 1'b1);
        send(64, -1, 0, -1, 1'b0);
        wait_idle("back_to_back");
        check_wire("back_to_back", 2, 12, 152);
        exp_fc += 2;
        check_counts("back_to_back", exp_fc, exp_ec);
    endtask

    task automatic test_tuser();
        fill_payload(60);
        obs.delete();
        push_frame(60, -1, 4, 1'b1, 1'b1, 1514);
        send(60, -1, 0, 4, 1'b0);
        wait_idle("tuser");
        check_wire("tuser", 1, -1, 72);
        exp_ec++;
        check_counts("tuser", exp_fc, exp_ec);
    endtask

    task automatic test_reset_midframe();
        logic en_before;
        fill_payload(10);
        for (int i = 0; i < 10; i++) drive_byte(payload[i], 1'b0, 1'b0);
        @(posedge clk);
        #2;
        en_before = m_en;
        rst_n = 1'b0;
        #1;
        tests++;
        if (en_before !== 1'b1) begin
            fails++;
            $display("FAIL midreset_active: tx_en=%b before reset, expected 1", en_before);
        end
        check_idle_outputs("midreset");
        tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_idle_outputs("post_reset");
    endtask

    initial begin
        rst_n  = 1'b0;
        sel    = 1'b0;
        tdata  = 8'h00;
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_crc_vector();
        test_pad();
        test_underrun();
        test_truncation();
        test_back_to_back();
        test_tuser();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
